// File: rtl/tag_memory_pkg.sv
// Shared sizing and per-entry storage layout for the 8-way, 16-set tag store.
package tag_memory_pkg;
  localparam int TAG_W    = 8;
  localparam int INDEX_W  = 4;
  localparam int WAY_W    = 3;
  localparam int NUM_WAYS = 1 << WAY_W;
  localparam int NUM_SETS = 1 << INDEX_W;

  typedef struct packed {
    logic             valid;
    logic             mod;
    logic [TAG_W-1:0] tag;
    logic [WAY_W-1:0] rank;
  } entry_t;
endpackage

// File: rtl/tag_lru_update.sv
// Rank-based LRU: computes post-touch ranks for one set and finds the rank-7 victim.
module tag_lru_update
  import tag_memory_pkg::*;
(
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] ranks,
  input  logic [WAY_W-1:0]               touch_way,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] new_ranks,
  output logic [WAY_W-1:0]               victim
);
  logic [WAY_W-1:0] old_rank;

  assign old_rank = ranks[touch_way];

  // Ways younger than the touched one age by one; rank < old_rank <= 7 cannot overflow.
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign new_ranks[w] = (touch_way == WAY_W'(w)) ? '0 :
                          (ranks[w] < old_rank)    ? ranks[w] + 1'b1 :
                                                     ranks[w];
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (ranks[w] == WAY_W'(NUM_WAYS-1)) victim = WAY_W'(w);
  end
endmodule

// File: rtl/tag_memory.sv
// Tag store with combinational lookup, victim report and single-edge allocate/dirty/touch updates.
module tag_memory
  import tag_memory_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [INDEX_W-1:0] index,
  input  logic               wr,
  input  logic               mod_in,
  input  logic               age,
  output logic [WAY_W-1:0]   chan,
  output logic [WAY_W-1:0]   age_chan,
  output logic [TAG_W-1:0]   age_tag,
  output logic               age_mod,
  output logic               hit
);
  entry_t mem [NUM_SETS][NUM_WAYS];

  logic [NUM_WAYS-1:0]            match;
  logic [NUM_WAYS-1:0][WAY_W-1:0] ranks;
  logic [NUM_WAYS-1:0][WAY_W-1:0] new_ranks;
  logic [WAY_W-1:0]               victim;
  logic [WAY_W-1:0]               touch_way;
  logic                           touch_en;
  logic                           alloc;

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = mem[index][w].valid && (mem[index][w].tag == tag_in);
      ranks[w] = mem[index][w].rank;
    end
  end

  // Allocation never duplicates a tag, so match is at most one-hot and OR-encoding is safe.
  always_comb begin
    chan = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (match[w]) chan = chan | WAY_W'(w);
  end

  assign hit       = |match;
  assign alloc     = wr && !hit;
  assign touch_en  = wr || (hit && (age || mod_in));
  assign touch_way = hit ? chan : victim;

  tag_lru_update u_lru (
    .ranks     (ranks),
    .touch_way (touch_way),
    .new_ranks (new_ranks),
    .victim    (victim)
  );

  assign age_chan = victim;
  assign age_tag  = mem[index][victim].tag;
  assign age_mod  = mem[index][victim].mod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          mem[s][w] <= '{valid: 1'b0, mod: 1'b0, tag: '0, rank: WAY_W'(NUM_WAYS-1-w)};
    end else begin
      if (touch_en)
        for (int w = 0; w < NUM_WAYS; w++)
          mem[index][w].rank <= new_ranks[w];
      if (alloc) begin
        mem[index][victim].valid <= 1'b1;
        mem[index][victim].tag   <= tag_in;
        mem[index][victim].mod   <= mod_in;
      end else if (hit && mod_in) begin
        mem[index][chan].mod <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tag_memory.sv
// Checks tag_memory against an MRU-ordered list model: directed scenarios then random traffic.
module tb_tag_memory;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tag_in;
  logic [3:0] index;
  logic       wr, mod_in, age;
  logic [2:0] chan, age_chan;
  logic [7:0] age_tag;
  logic       age_mod, hit;

  int errors = 0;
  int checks = 0;

  // Model: per set, validity/tag/dirty per way plus a recency list (front = MRU, back = LRU).
  bit       m_vld [16][8];
  bit [7:0] m_tag [16][8];
  bit       m_mod [16][8];
  int       order [16][$];

  tag_memory dut (
    .clk(clk), .rst_n(rst_n), .tag_in(tag_in), .index(index), .wr(wr),
    .mod_in(mod_in), .age(age), .chan(chan), .age_chan(age_chan),
    .age_tag(age_tag), .age_mod(age_mod), .hit(hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      order[s].delete();
      for (int w = 0; w < 8; w++) begin
        m_vld[s][w] = 0; m_tag[s][w] = 0; m_mod[s][w] = 0;
        order[s].push_front(w);   // way 7 ends up MRU, way 0 LRU
      end
    end
  endfunction

  function automatic int model_way(input int s, input bit [7:0] t);
    for (int w = 0; w < 8; w++)
      if (m_vld[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic void touch(input int s, input int w);
    for (int i = 0; i < order[s].size(); i++)
      if (order[s][i] == w) begin order[s].delete(i); break; end
    order[s].push_front(w);
  endfunction

  task automatic cmp_model(input string pfx);
    int s, w, v;
    s = index; w = model_way(s, tag_in); v = order[s][7];
    chk({pfx, "_hit"},      int'(hit),      int'(w >= 0));
    chk({pfx, "_chan"},     int'(chan),     (w >= 0) ? w : 0);
    chk({pfx, "_age_chan"}, int'(age_chan), v);
    chk({pfx, "_age_tag"},  int'(age_tag),  int'(m_tag[s][v]));
    chk({pfx, "_age_mod"},  int'(age_mod),  int'(m_mod[s][v]));
  endtask

  task automatic look(input bit [3:0] idx, input bit [7:0] t);
    wr = 0; mod_in = 0; age = 0; index = idx; tag_in = t;
    #1;
    cmp_model("look");
  endtask

  task automatic step(input bit w_i, input bit m_i, input bit a_i,
                      input bit [3:0] idx, input bit [7:0] t);
    int s, w, v;
    wr = w_i; mod_in = m_i; age = a_i; index = idx; tag_in = t;
    #1;
    cmp_model("pre");
    s = idx; w = model_way(s, t); v = order[s][7];
    @(posedge clk);
    if (w_i) begin
      if (w >= 0) begin
        touch(s, w); if (m_i) m_mod[s][w] = 1;
      end else begin
        m_vld[s][v] = 1; m_tag[s][v] = t; m_mod[s][v] = m_i; touch(s, v);
      end
    end else if (w >= 0) begin
      if (m_i) m_mod[s][w] = 1;
      if (a_i || m_i) touch(s, w);
    end
    #1;
    wr = 0; mod_in = 0; age = 0;
  endtask

  initial begin
    rst_n = 0; wr = 0; mod_in = 0; age = 0; index = 4'hF; tag_in = 8'd1;
    model_reset();
    #12;
    rst_n = 1;
    #1;
    chk("rst_hit", int'(hit), 0);
    chk("rst_age_chan", int'(age_chan), 0);
    chk("rst_age_tag", int'(age_tag), 0);
    chk("rst_age_mod", int'(age_mod), 0);
    chk("rst_chan", int'(chan), 0);
    @(posedge clk); #1;

    // Fill set F: tag t lands in way t-1
    for (int t = 1; t <= 8; t++) step(1, 0, 0, 4'hF, 8'(t));
    for (int t = 1; t <= 8; t++) begin
      look(4'hF, 8'(t));
      chk("fill_chan", int'(chan), t - 1);
    end
    look(4'hF, 8'd3);
    chk("fill_hit3", int'(hit), 1);
    chk("fill_victim", int'(age_chan), 0);
    chk("fill_victim_tag", int'(age_tag), 1);

    // Touch tags 5,6,7
    for (int t = 5; t <= 7; t++) step(0, 0, 1, 4'hF, 8'(t));
    look(4'hF, 8'd9);
    chk("touch_miss9", int'(hit), 0);
    chk("touch_victim_tag", int'(age_tag), 1);

    // Dirty 5,6,7 then touch 1..4 and 8
    for (int t = 5; t <= 7; t++) step(0, 1, 0, 4'hF, 8'(t));
    for (int t = 1; t <= 4; t++) step(0, 0, 1, 4'hF, 8'(t));
    step(0, 0, 1, 4'hF, 8'd8);
    look(4'hF, 8'd0);
    chk("dirty_victim", int'(age_chan), 4);
    chk("dirty_victim_tag", int'(age_tag), 5);
    chk("dirty_victim_mod", int'(age_mod), 1);

    // Eviction of way 4 by tag 0x20
    look(4'hF, 8'h20);
    chk("evict_pre_tag", int'(age_tag), 5);
    step(1, 0, 0, 4'hF, 8'h20);
    look(4'hF, 8'h20);
    chk("evict_hit", int'(hit), 1);
    chk("evict_chan", int'(chan), 4);
    look(4'hF, 8'd5);
    chk("evict_old_miss", int'(hit), 0);

    // Miss without wr changes nothing; isolation across sets
    step(0, 1, 1, 4'hF, 8'h77);
    step(1, 1, 0, 4'h3, 8'h44);
    look(4'hF, 8'd3);
    chk("iso_hit", int'(hit), 1);
    chk("iso_chan", int'(chan), 2);
    look(4'h3, 8'h44);
    chk("iso_set3_mod", int'(age_mod), 0);

    // Async reset between edges
    look(4'hF, 8'h20);
    rst_n = 0;
    #1;
    chk("async_rst_hit", int'(hit), 0);
    chk("async_rst_age_tag", int'(age_tag), 0);
    model_reset();
    #2;
    rst_n = 1;
    @(posedge clk); #1;

    // Random traffic on a few sets with a small tag space to force hits and evictions
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 0; #1;
        chk("rnd_rst_hit", int'(hit), 0);
        model_reset();
        rst_n = 1;
      end
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)) | 4'hC,
           8'($urandom_range(0, 11)));
    end
    for (int s = 12; s < 16; s++)
      for (int t = 0; t < 12; t++) look(4'(s), 8'(t));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
